// File: rtl/tea_io_bridge.sv
// tea_io_bridge: CPU I/O-bus bridge with RX/TX byte FIFOs, status/count/ctrl registers and host valid/ready streams.
// Optional loopback (TX head -> RX) is built only when TEA_IO_LOOPBACK_EN is defined.
module tea_io_bridge #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] io_addr,
  input  logic       io_rd,
  input  logic       io_wr,
  input  logic [7:0] io_wrdata,
  output logic [7:0] io_rddata,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0] cnt_t;
  logic [7:0] rx_mem [DEPTH];
  logic [7:0] tx_mem [DEPTH];
  ptr_t rx_wp, rx_rp, tx_wp, tx_rp;
  cnt_t rx_cnt, tx_cnt;
  logic wr_q, rd_q, hold, rd_dat, rx_udf, tx_ovf, loop, lb_move;
  logic rx_empty, rx_full, tx_empty, tx_full, wr_go, rd_go, rd_end, ctrl;
  logic rx_push, rx_pop, tx_push, tx_pop, rx_flush, tx_flush, clr, udf_set, ovf_set;
  logic [7:0] rx_head, tx_head, rx_in, status;
  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt == cnt_t'(DEPTH);
  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == cnt_t'(DEPTH);
  assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp];
  assign tx_head  = tx_mem[tx_rp];
  // hold masks a strobe that was already active across reset, so it has no side effect
  assign wr_go    = io_wr && !wr_q && !hold;
  assign rd_go    = io_rd && !rd_q && !hold;
  assign rd_end   = rd_dat && !io_rd;
  assign ctrl     = wr_go && io_addr == 5'd4;
  assign clr      = ctrl && io_wrdata[0];
  assign rx_flush = ctrl && io_wrdata[1];
  assign tx_flush = ctrl && io_wrdata[2];
  assign tx_push  = wr_go && io_addr == 5'd0 && !tx_full;
  assign ovf_set  = wr_go && io_addr == 5'd0 && tx_full;
  assign udf_set  = rd_end && rx_empty;
`ifdef TEA_IO_LOOPBACK_EN
  always_ff @(posedge clk)
    loop <= rst ? 1'b0 : ctrl ? io_wrdata[3] : loop;
  assign lb_move = loop && !tx_empty && !rx_full;
`else
  assign loop    = 1'b0;
  assign lb_move = 1'b0;
`endif
  assign rx_ready = !rx_full && !loop;
  assign tx_valid = !tx_empty && !loop;
  assign tx_data  = tx_empty ? 8'h00 : tx_head;
  assign rx_push  = (rx_valid && rx_ready) || lb_move;
  assign rx_pop   = rd_end && !rx_empty;
  assign tx_pop   = (tx_valid && tx_ready) || lb_move;
  assign rx_in    = lb_move ? tx_head : rx_data;
  assign status   = {1'b0, loop, tx_ovf, rx_udf, tx_full, tx_empty, rx_full, rx_empty};
  always_comb
    io_rddata = !io_rd ? 8'h00 :
                io_addr == 5'd0 ? rx_head :
                io_addr == 5'd1 ? status :
                io_addr == 5'd2 ? 8'(rx_cnt) :
                io_addr == 5'd3 ? 8'(tx_cnt) : 8'h00;
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_in;
    if (tx_push) tx_mem[tx_wp] <= io_wrdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      rd_dat <= 1'b0;
      hold   <= io_wr || io_rd;
      rx_udf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      wr_q   <= io_wr;
      rd_q   <= io_rd;
      rd_dat <= (rd_go && io_addr == 5'd0) ? 1'b1 : io_rd ? rd_dat : 1'b0;
      hold   <= hold && (io_wr || io_rd);
      rx_udf <= clr ? 1'b0 : rx_udf || udf_set;
      tx_ovf <= clr ? 1'b0 : tx_ovf || ovf_set;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      rx_wp  <= rx_wp + ptr_t'(rx_push);
      rx_rp  <= rx_rp + ptr_t'(rx_pop);
      rx_cnt <= rx_cnt + cnt_t'(rx_push) - cnt_t'(rx_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      tx_wp  <= tx_wp + ptr_t'(tx_push);
      tx_rp  <= tx_rp + ptr_t'(tx_pop);
      tx_cnt <= tx_cnt + cnt_t'(tx_push) - cnt_t'(tx_pop);
    end
  end
endmodule

// File: tb/tb_tea_io_bridge.sv
// tb_tea_io_bridge: directed and random checks of tea_io_bridge against a queue-based transaction model.
module tb_tea_io_bridge;
  localparam int DL = 3;
  localparam int DEPTH = 1 << DL;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] io_addr;
  logic io_rd, io_wr, rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0] io_wrdata, io_rddata, rx_data, tx_data;
  logic [7:0] rxq[$], txq[$];
  bit udf, ovf, loop;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  tea_io_bridge #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
    .io_wrdata(io_wrdata), .io_rddata(io_rddata), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] status_m();
    return {1'b0, loop, ovf, udf, txq.size() == DEPTH, txq.size() == 0,
            rxq.size() == DEPTH, rxq.size() == 0};
  endfunction
  function automatic logic [7:0] exp_rd(input logic [4:0] a);
    case (a)
      5'd0: return rxq.size() > 0 ? rxq[0] : 8'h00;
      5'd1: return status_m();
      5'd2: return 8'(rxq.size());
      5'd3: return 8'(txq.size());
      default: return 8'h00;
    endcase
  endfunction
  task automatic loop_move();
    while (loop && txq.size() > 0 && rxq.size() < DEPTH) rxq.push_back(txq.pop_front());
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    io_addr = a; io_wrdata = d; io_wr = 1'b1;
    step();
    if (a == 5'd0) begin
      if (txq.size() == DEPTH) ovf = 1'b1;
      else txq.push_back(d);
    end else if (a == 5'd4) begin
      if (d[0]) begin udf = 1'b0; ovf = 1'b0; end
      if (d[1]) rxq.delete();
      if (d[2]) txq.delete();
`ifdef TEA_IO_LOOPBACK_EN
      loop = d[3];
`endif
    end
    chk("wr_tx_valid", 8'(tx_valid), 8'(!loop && txq.size() > 0));
    step();
    io_wr = 1'b0;
    step();
    step();
    loop_move();
  endtask
  task automatic rd(input logic [4:0] a, input string tag);
    logic [7:0] e;
    e = exp_rd(a);
    io_addr = a; io_rd = 1'b1;
    #1 chk(tag, io_rddata, e);
    step();
    chk({tag, "_hold"}, io_rddata, e);
    step();
    io_rd = 1'b0;
    step();
    step();
    if (a == 5'd0) begin
      if (rxq.size() == 0) udf = 1'b1;
      else void'(rxq.pop_front());
    end
    loop_move();
  endtask
  task automatic host_push(input logic [7:0] d);
    logic r;
    r = !loop && rxq.size() < DEPTH;
    rx_valid = 1'b1; rx_data = d;
    #1 chk("rx_ready", 8'(rx_ready), 8'(r));
    step();
    rx_valid = 1'b0;
    if (r) rxq.push_back(d);
  endtask
  task automatic host_pop();
    logic v;
    v = !loop && txq.size() > 0;
    tx_ready = 1'b1;
    #1 chk("tx_valid", 8'(tx_valid), 8'(v));
    chk("tx_data", tx_data, txq.size() > 0 ? txq[0] : 8'h00);
    step();
    tx_ready = 1'b0;
    if (v) void'(txq.pop_front());
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
  initial begin
    io_addr = '0; io_rd = 1'b0; io_wr = 1'b0; io_wrdata = '0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    udf = 1'b0; ovf = 1'b0; loop = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_rx_ready", 8'(rx_ready), 8'h01);
    chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rddata", io_rddata, 8'h00);
    rd(5'd1, "rst_status");
    chk("rst_status_const", 8'h05, status_m());
    rd(5'd2, "rst_rx_cnt");
    rd(5'd3, "rst_tx_cnt");
    io_addr = 5'd0; io_wrdata = 8'hEE; io_wr = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    io_wr = 1'b0;
    step();
    step();
    rd(5'd3, "rst_mid_tx_cnt");
    host_push(8'hA5);
    host_push(8'h3C);
    rd(5'd2, "rx_cnt2");
    rd(5'd0, "rd_a5");
    rd(5'd2, "rx_cnt1");
    rd(5'd0, "rd_3c");
    rd(5'd2, "rx_cnt0");
    rd(5'd1, "status_no_udf");
    for (int i = 0; i < 9; i++) wr(5'd0, 8'(8'h10 + i));
    rd(5'd3, "tx_cnt_full");
    rd(5'd1, "status_tx_full_ovf");
    for (int i = 0; i < 8; i++) host_pop();
    host_pop();
    rd(5'd0, "rd_empty");
    rd(5'd1, "status_udf");
    wr(5'd4, 8'h01);
    rd(5'd1, "status_clr");
    host_push(8'h77);
    io_addr = 5'd0; io_rd = 1'b1;
    #1 chk("co_rd", io_rddata, 8'h77);
    step();
    step();
    io_rd = 1'b0; rx_valid = 1'b1; rx_data = 8'h99;
    step();
    rx_valid = 1'b0;
    void'(rxq.pop_front());
    rxq.push_back(8'h99);
    step();
    step();
    rd(5'd2, "co_rx_cnt");
    rd(5'd0, "co_rd_99");
    for (int i = 0; i < 9; i++) host_push(8'(8'hC0 + i));
    rd(5'd1, "status_rx_full");
    wr(5'd4, 8'h06);
    rd(5'd1, "status_flushed");
    wr(5'd9, 8'hFF);
    rd(5'd4, "ctrl_reads0");
    rd(5'd9, "other_reads0");
`ifdef TEA_IO_LOOPBACK_EN
    wr(5'd4, 8'h08);
    chk("lb_rx_ready", 8'(rx_ready), 8'h00);
    wr(5'd0, 8'h5A);
    chk("lb_tx_valid", 8'(tx_valid), 8'h00);
    rd(5'd2, "lb_rx_cnt");
    rd(5'd1, "lb_status");
    rd(5'd0, "lb_rd_5a");
    wr(5'd4, 8'h00);
    rd(5'd1, "lb_off_status");
`endif
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 7))
        0, 1: host_push(8'($urandom));
        2: rd(5'd0, "rnd_rd_data");
        3, 4: wr(5'd0, 8'($urandom));
        5: host_pop();
        6: rd(5'($urandom_range(1, 7)), "rnd_rd_reg");
        default: begin
          if ($urandom_range(0, 3) == 0) wr(5'd4, 8'($urandom_range(0, 7)));
          else wr(5'($urandom_range(5, 31)), 8'($urandom));
        end
      endcase
    end
    rd(5'd1, "final_status");
    rd(5'd2, "final_rx_cnt");
    rd(5'd3, "final_tx_cnt");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tea_io_bridge.md
# tea_io_bridge

Byte-stream bridge on the TEA CPU I/O bus. It gives firmware two FIFOs and a small register map, reached through the ioop-prefixed load/store accesses. An external host exchanges bytes with the CPU over valid/ready streams. This is the block directly downstream of the CPU `io_*` port.

## Interface
- `DEPTH_LOG2`, 3: log2 of the depth of each FIFO (8 entries). Legal range 1..7.
- `clk` in 1: clock.
- `rst` in 1: reset rst, synchronous, active-high; clock clk.
- `io_addr` in 5: register select, from the CPU.
- `io_rd` in 1: read strobe. Held high for 2 consecutive cycles per access.
- `io_wr` in 1: write strobe. Held high for 2 consecutive cycles per access.
- `io_wrdata` in 8: write data (CPU acc). Stable while `io_wr` is high.
- `io_rddata` out 8: read data, combinational.
- `rx_valid` in 1, `rx_data` in 8, `rx_ready` out 1: host→CPU stream.
- `tx_valid` out 1, `tx_data` out 8, `tx_ready` in 1: CPU→host stream.

## Operation
- Two FIFOs, each `2**DEPTH_LOG2` × 8, with a count register of `DEPTH_LOG2+1` bits:
  - RX FIFO: host → CPU.
  - TX FIFO: CPU → host.
- Register map (`io_addr`):
  - 0x00 DATA: a read returns the RX head and pops it; a write pushes to TX.
  - 0x01 STATUS, read-only:
    - b0 rx_empty, b1 rx_full, b2 tx_empty, b3 tx_full
    - b4 rx_udf (sticky), b5 tx_ovf (sticky), b6 loopback, b7 0.
  - 0x02 RX_COUNT and 0x03 TX_COUNT, read-only, zero-extended to 8 bits.
  - 0x04 CTRL, write-only, reads 0:
    - b0 clears rx_udf and tx_ovf.
    - b1 flushes RX; b2 flushes TX.
    - b3 sets the loopback enable (see Configuration).
  - Any other address reads 0x00; writes to it are ignored.
- Each CPU access has exactly one side effect, whatever the strobe length:
  - Write acts on the rising edge of `io_wr`.
  - Read pop happens in the cycle after `io_rd` falls, so the head stays stable for the whole access.
- Write to DATA with TX full: data is dropped and tx_ovf is set.
- Read of DATA with RX empty: returns 0x00, no pop, and rx_udf is set.
- Host streams:
  - `rx_ready = !rx_full`; a push happens when `rx_valid && rx_ready`.
  - `tx_valid = !tx_empty`; `tx_data` is the TX head, or 0x00 when empty. A pop happens when `tx_valid && tx_ready`.
- Simultaneous push and pop on one FIFO: both occur and the count is unchanged.
  - A pop that empties the FIFO in the same cycle as a push leaves one entry: the pushed byte.
- A flush has priority over a same-cycle push or pop on that FIFO: count → 0, pointers → 0.
- A CTRL b0 clear has priority over a same-cycle sticky set.
- Pointers wrap modulo depth. Counts saturate naturally, because full blocks a push and empty blocks a pop.

## Timing
- Reset values:
  - counts, pointers and sticky flags are 0; loopback is 0; edge-detect registers are 0.
  - `rx_ready`=1, `tx_valid`=0, `tx_data`=0x00, `io_rddata`=0x00.
  - Reset mid-access discards the access; no side effect afterwards.
- `io_rddata` is combinational from `io_addr` and the current state, and reads 0x00 while `io_rd` is low. A STATUS or COUNT read reflects host-side activity in the same cycle.
- A CPU DATA write is visible on `tx_valid`/`tx_data` 1 cycle after the `io_wr` rising edge.
- A host RX push is visible to a CPU read 1 cycle after the handshake.
- The minimum spacing between CPU accesses (2 idle cycles) guarantees a read pop has completed before the next access.

## Configuration
- `TEA_IO_LOOPBACK_EN` defined:
  - CTRL b3 sets or clears loopback.
  - While loopback is set, the TX head moves into RX whenever TX is non-empty and RX is not full: one byte per cycle, latency 1.
  - While loopback is set, `rx_ready`=0 and `tx_valid`=0, and STATUS b6 reads 1.
- Undefined: CTRL b3 is ignored and STATUS b6 reads 0. No loopback logic is built.

## Test plan
- Reset, then idle: `rx_ready`=1, `tx_valid`=0, STATUS=0x05, RX_COUNT=0, TX_COUNT=0.
- Host pushes 0xA5 then 0x3C; CPU reads DATA twice (2-cycle strobes). Required: reads return 0xA5 then 0x3C, RX_COUNT goes 2→1→0, and rx_udf stays 0.
- CPU writes 9 bytes 0x10..0x18 to DATA with `tx_ready`=0 (DEPTH_LOG2=3). Required: TX_COUNT=8 and STATUS b3=1, b5=1. Then `tx_ready`=1: host receives 0x10..0x17 in order.
- Read DATA with RX empty: returns 0x00 and STATUS b4=1. Then write CTRL=0x01: STATUS b4=0.
- Host push coincides with a CPU pop on an RX holding 1 entry: RX_COUNT stays 1 and the next read returns the pushed byte.
- With `TEA_IO_LOOPBACK_EN`: write CTRL=0x08, then write DATA 0x5A. Required: after 2 cycles RX_COUNT=1 and DATA reads 0x5A; `tx_valid` stays 0 throughout.
